// File: rtl/vga_tile_pkg.sv
// Shared constants, types and helpers for the tile renderer.
// Latency: n/a.
// Backpressure: n/a.
package vga_tile_pkg;

    localparam int TILE_PX   = 32;
    localparam int TILE_SH   = $clog2(TILE_PX);
    localparam int MAP_COLS  = 20;
    localparam int MAP_ROWS  = 15;
    localparam int MAP_DEPTH = MAP_COLS * MAP_ROWS;
    localparam int MAP_AW    = 9;

    typedef enum logic [2:0] {
        TILE_EMPTY   = 3'd0,
        TILE_WALL    = 3'd1,
        TILE_BRICK   = 3'd2,
        TILE_BOMB    = 3'd3,
        TILE_FIRE    = 3'd4,
        TILE_PLAYER  = 3'd5,
        TILE_ENEMY   = 3'd6,
        TILE_POWERUP = 3'd7
    } tile_t;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    // 12-bit {R,G,B}; entry 0 is black so an empty tile renders as background.
    localparam logic [11:0] PALETTE [16] = '{
        12'h000, 12'h111, 12'h840, 12'hA50,
        12'hC62, 12'hE84, 12'h333, 12'h555,
        12'hF00, 12'hFF0, 12'hF80, 12'hFC0,
        12'h00F, 12'h0FF, 12'h0F0, 12'hFFF
    };

    function automatic logic [MAP_AW-1:0] map_index(input logic [3:0] row, input logic [4:0] col);
        return MAP_AW'(row) * MAP_AW'(MAP_COLS) + MAP_AW'(col);
    endfunction

    // Tile bitmap image: {tile[2:0], sub[7:0]} -> 4-bit palette index.
    // Empty tile is solid colour 0; every other tile is a two-tone dither whose
    // tone is the parity of the 16x16 sub-pixel coordinates.
    function automatic logic [3:0] tile_rom(input logic [10:0] rom_addr);
        if (rom_addr[10:8] == 3'd0)
            return 4'h0;
        return {rom_addr[10:8], ^rom_addr[7:0]};
    endfunction

endpackage

// File: rtl/tile_map_ram.sv
// 300 x 3-bit tile map, simple dual port: sync write, sync read-first.
// Latency: one clk from rd_addr (when re=1) to rd_data.
// Backpressure: none; re=0 holds rd_data. Ports: clk, we/wr_addr/wr_data, re/rd_addr/rd_data.
module tile_map_ram
    import vga_tile_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [MAP_AW-1:0] wr_addr,
    input  tile_t             wr_data,
    input  logic              re,
    input  logic [MAP_AW-1:0] rd_addr,
    output tile_t             rd_data
);

    tile_t mem [MAP_DEPTH];

    // Read and write in the same process: the read samples the old contents
    // when both hit one address on the same clk.
    always_ff @(posedge clk) begin
        if (re)
            rd_data <= (rd_addr < MAP_AW'(MAP_DEPTH)) ? mem[rd_addr] : TILE_EMPTY;
        if (we && (wr_addr < MAP_AW'(MAP_DEPTH)))
            mem[wr_addr] <= wr_data;
    end

endmodule

// File: rtl/tile_renderer.sv
// Tile-map pixel pipeline: (x_pos, y_pos, display_on, syncs) -> 12-bit rgb, hsync, vsync.
// Latency: 3 p_tick for rgb/hsync/vsync alike; map clear takes 300 clk after reset (init_busy).
// Backpressure: pipeline only moves on p_tick, otherwise holds. Optional DEBUG_GRID_EN adds a white tile grid.
// Ports: clk, reset (sync, active-high), p_tick, display_on, hsync_in, vsync_in, x_pos, y_pos,
//        wr_en/wr_col/wr_row/wr_tile (map write), init_busy, hsync, vsync, rgb.
module tile_renderer
    import vga_tile_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        p_tick,
    input  logic        display_on,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic [9:0]  x_pos,
    input  logic [9:0]  y_pos,
    input  logic        wr_en,
    input  logic [4:0]  wr_col,
    input  logic [3:0]  wr_row,
    input  logic [2:0]  wr_tile,
    output logic        init_busy,
    output logic        hsync,
    output logic        vsync,
    output logic [11:0] rgb
);

    state_t            state, state_nxt;
    logic [MAP_AW-1:0] clr_addr, clr_addr_nxt;
    logic              map_we;
    logic [MAP_AW-1:0] map_wa;
    tile_t             map_wd;

    // Pixel LSBs and y_pos[9] carry no information for 2x-upscaled 32-px tiles.
    logic unused_pos_bits;
    assign unused_pos_bits = ^{y_pos[9], y_pos[0], x_pos[0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_CLEAR;
            clr_addr <= '0;
        end else begin
            state    <= state_nxt;
            clr_addr <= clr_addr_nxt;
        end
    end

    // The clear sweep owns the map write port, so game writes are simply lost while it runs.
    always_comb begin
        state_nxt    = state;
        clr_addr_nxt = clr_addr;
        init_busy    = 1'b0;
        map_we       = 1'b0;
        map_wa       = map_index(wr_row, wr_col);
        map_wd       = tile_t'(wr_tile);
        case (state)
            ST_CLEAR: begin
                init_busy    = 1'b1;
                map_we       = 1'b1;
                map_wa       = clr_addr;
                map_wd       = TILE_EMPTY;
                clr_addr_nxt = clr_addr + MAP_AW'(1);
                if (clr_addr == MAP_AW'(MAP_DEPTH - 1)) begin
                    state_nxt    = ST_RUN;
                    clr_addr_nxt = '0;
                end
            end
            ST_RUN: begin
                map_we = wr_en && (wr_col < 5'(MAP_COLS)) && (wr_row < 4'(MAP_ROWS));
            end
            default: state_nxt = ST_CLEAR;
        endcase
    end

    // S1: map address and sub-tile coordinate.
    logic [MAP_AW-1:0] s1_addr;
    logic [7:0]        s1_sub;
    logic              s1_disp, s1_hs, s1_vs;
    // S2: tile read from map (inside the RAM) plus carried flags.
    logic [7:0]        s2_sub;
    logic              s2_disp, s2_hs, s2_vs;
    tile_t             s2_tile;
    logic [11:0]       pix_rgb;
`ifdef DEBUG_GRID_EN
    logic              s1_grid, s2_grid;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_addr <= '0;
            s1_sub  <= '0;
            s1_disp <= 1'b0;
            s1_hs   <= 1'b0;
            s1_vs   <= 1'b0;
            s2_sub  <= '0;
            s2_disp <= 1'b0;
            s2_hs   <= 1'b0;
            s2_vs   <= 1'b0;
        end else if (p_tick) begin
            s1_addr <= map_index(y_pos[8:TILE_SH], x_pos[9:TILE_SH]);
            s1_sub  <= {y_pos[TILE_SH-1:1], x_pos[TILE_SH-1:1]};
            s1_disp <= display_on;
            s1_hs   <= hsync_in;
            s1_vs   <= vsync_in;
            s2_sub  <= s1_sub;
            s2_disp <= s1_disp;
            s2_hs   <= s1_hs;
            s2_vs   <= s1_vs;
        end
    end

`ifdef DEBUG_GRID_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_grid <= 1'b0;
            s2_grid <= 1'b0;
        end else if (p_tick) begin
            s1_grid <= (x_pos[TILE_SH-1:0] == '0) || (y_pos[TILE_SH-1:0] == '0);
            s2_grid <= s1_grid;
        end
    end
`endif

    tile_map_ram u_map (
        .clk     (clk),
        .we      (map_we),
        .wr_addr (map_wa),
        .wr_data (map_wd),
        .re      (p_tick),
        .rd_addr (s1_addr),
        .rd_data (s2_tile)
    );

    always_comb begin
        pix_rgb = PALETTE[tile_rom({s2_tile, s2_sub})];
`ifdef DEBUG_GRID_EN
        if (s2_grid)
            pix_rgb = 12'hFFF;
`endif
    end

    // S3: colour out; blanked while the map is being cleared.
    always_ff @(posedge clk) begin
        if (reset) begin
            rgb   <= '0;
            hsync <= 1'b0;
            vsync <= 1'b0;
        end else if (p_tick) begin
            hsync <= s2_hs;
            vsync <= s2_vs;
            rgb   <= (s2_disp && (state == ST_RUN)) ? pix_rgb : 12'h000;
        end
    end

endmodule
